// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one fp32 multiplier between NREQ requesters, one operation in
// flight, with a watchdog that recovers a hung multiplier and answers with a canonical NaN.
module fp_mult_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_stb,
    input  logic [32*NREQ-1:0]       req_a,
    input  logic [32*NREQ-1:0]       req_b,
    output logic [NREQ-1:0]          req_busy,
    output logic [31:0]              rsp_data,
    output logic [NREQ-1:0]          rsp_stb,
    input  logic [NREQ-1:0]          rsp_busy,
    output logic [31:0]              m_a,
    output logic [31:0]              m_b,
    output logic                     m_input_stb,
    input  logic                     m_busy,
    input  logic [31:0]              m_result,
    input  logic                     m_output_stb,
    output logic                     m_output_busy,
    output logic                     m_rst,
    output logic                     err_timeout,
    output logic [$clog2(NREQ)-1:0]  grant_tag
);
    localparam int TAG_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [31:0]     QNAN    = 32'hFFC00000;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t            r_state, w_next;
    logic [TAG_W-1:0]  r_rr_ptr, r_tag, w_win;
    logic              w_win_vld;
    logic [WD_W-1:0]   r_wdog;
    logic              r_mrst_pulse;
    logic [31:0]       r_m_a, r_m_b, r_rsp_data;
    logic              r_m_stb, r_m_obusy, r_err;
    logic [NREQ-1:0]   r_rsp_stb, w_tag_oh;
    logic              w_req_xfer, w_iss_xfer, w_res_xfer, w_wd_fire, w_rsp_xfer;
    int                w_idx;

    // Round-robin search: the lowest offset from r_rr_ptr with a pending request wins.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (req_stb[w_idx]) begin
                w_win     = TAG_W'(w_idx);
                w_win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_busy = '1;
        if (r_state == S_IDLE && w_win_vld) req_busy[w_win] = 1'b0;
    end

    assign w_tag_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_tag;
    assign w_req_xfer = (r_state == S_IDLE) && w_win_vld;
    assign w_iss_xfer = (r_state == S_ISSUE) && r_m_stb && !m_busy;
    assign w_res_xfer = (r_state == S_WAIT) && m_output_stb && !r_m_obusy;
    // A result sampled on the terminal watchdog cycle wins over the timeout.
    assign w_wd_fire  = (r_state == S_WAIT) && !m_output_stb && (r_wdog == WD_LAST);
    assign w_rsp_xfer = (r_state == S_DELIVER) && !rsp_busy[r_tag];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req_xfer) w_next = S_ISSUE;
            S_ISSUE:   if (w_iss_xfer) w_next = S_WAIT;
            S_WAIT:    if (w_res_xfer || w_wd_fire) w_next = S_DELIVER;
            S_DELIVER: if (w_rsp_xfer) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_tag        <= '0;
            r_wdog       <= '0;
            r_mrst_pulse <= 1'b0;
            r_m_a        <= '0;
            r_m_b        <= '0;
            r_m_stb      <= 1'b0;
            r_m_obusy    <= 1'b1;
            r_rsp_data   <= '0;
            r_rsp_stb    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_mrst_pulse <= w_wd_fire;
            if (w_req_xfer) begin
                r_m_a    <= req_a[32*int'(w_win) +: 32];
                r_m_b    <= req_b[32*int'(w_win) +: 32];
                r_tag    <= w_win;
                r_rr_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
                r_m_stb  <= 1'b1;
            end
            if (w_iss_xfer) begin
                r_m_stb   <= 1'b0;
                r_m_obusy <= 1'b0;
                r_wdog    <= '0;
            end
            if (r_state == S_WAIT) begin
                if (w_res_xfer) begin
                    r_rsp_data <= m_result;
                    r_rsp_stb  <= w_tag_oh;
                    r_m_obusy  <= 1'b1;
                end else if (w_wd_fire) begin
                    r_err      <= 1'b1;
                    r_rsp_data <= QNAN;
                    r_rsp_stb  <= w_tag_oh;
                    r_m_obusy  <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
            if (w_rsp_xfer) r_rsp_stb <= '0;
        end
    end

    assign m_a           = r_m_a;
    assign m_b           = r_m_b;
    assign m_input_stb   = r_m_stb;
    assign m_output_busy = r_m_obusy;
    assign m_rst         = rst | r_mrst_pulse;
    assign rsp_data      = r_rsp_data;
    assign rsp_stb       = r_rsp_stb;
    assign err_timeout   = r_err;
    assign grant_tag     = r_tag;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: directed and random operations against a stub multiplier,
// with a round-robin / fp32-product reference model.
module tb_fp_mult_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 32;
    localparam logic [31:0]     QNAN = 32'hFFC00000;
    localparam logic [NREQ-1:0] ALL1 = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req_stb, req_busy, rsp_stb, rsp_busy;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [31:0]         rsp_data, m_a, m_b, m_result;
    logic                m_input_stb, m_busy, m_output_stb, m_output_busy, m_rst, err_timeout;
    logic [1:0]          grant_tag;

    fp_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_stb(req_stb), .req_a(req_a), .req_b(req_b),
        .req_busy(req_busy), .rsp_data(rsp_data), .rsp_stb(rsp_stb), .rsp_busy(rsp_busy),
        .m_a(m_a), .m_b(m_b), .m_input_stb(m_input_stb), .m_busy(m_busy),
        .m_result(m_result), .m_output_stb(m_output_stb), .m_output_busy(m_output_busy),
        .m_rst(m_rst), .err_timeout(err_timeout), .grant_tag(grant_tag)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int model_rr = 0;
    bit err_model = 0;
    int fires = 0;
    int mrst_hi = 0;
    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];

    // fp32 multiply for normal operands with in-range results, truncating.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int e;
        logic [22:0] f;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin f = p[46:24]; e = e + 1; end
        else f = p[45:23];
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(64, 190));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
        end
    endtask

    // Stub multiplier: samples handshakes on the rising edge, drives on the falling edge.
    int          stub_lat = 2;
    bit          stub_hang = 0;
    bit          p_rst = 0, p_in = 0, p_out = 0;
    logic [31:0] p_res = '0, res_hold = '0;
    int          cnt = -1;

    always @(posedge clk) begin
        p_rst = m_rst;
        p_in  = m_input_stb && !m_busy;
        p_out = m_output_stb && !m_output_busy;
        if (p_in) p_res = fp_mul(m_a, m_b);
        if (!rst && m_rst) mrst_hi++;
    end

    always @(negedge clk) begin
        if (p_rst) begin
            cnt = -1;
            m_output_stb = 1'b0;
        end else begin
            if (p_out) m_output_stb = 1'b0;
            if (p_in) begin
                cnt = stub_lat;
                res_hold = p_res;
            end else if (cnt > 0) cnt--;
            if (cnt == 0 && !stub_hang) begin
                m_output_stb = 1'b1;
                m_result = res_hold;
                cnt = -1;
            end
        end
    end

    initial begin
        m_output_stb = 1'b0;
        m_result = '0;
    end

    // One complete operation; the expected winner comes from the round-robin model.
    task automatic one_op(input logic [NREQ-1:0] mask, input int lat, input bit hang,
                          input bit exp_nan, input int bp, input int stall);
        int w, n;
        logic [NREQ-1:0] oh, noh;
        logic [31:0] exp_d, d0;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && mask[(model_rr + k) % NREQ]) w = (model_rr + k) % NREQ;
        end
        oh  = NREQ'(1) << w;
        noh = ~oh;
        stub_lat = lat;
        stub_hang = hang;
        load_ops();
        req_stb = mask;
        rsp_busy = (bp > 0) ? oh : noh;
        if (stall > 0) m_busy = 1'b1;
        #1;
        chk("req_busy_idle", req_busy, noh);
        exp_d = exp_nan ? QNAN : fp_mul(a_arr[w], b_arr[w]);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("issue_stb_held", m_input_stb, 1);
            chk("issue_m_a", m_a, a_arr[w]);
            chk("issue_m_b", m_b, b_arr[w]);
            chk("issue_req_busy", req_busy, ALL1);
            m_busy = 1'b0;
        end
        n = 0;
        while (rsp_stb === '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", 32'(n < 200), 1);
        chk("rsp_stb", rsp_stb, oh);
        chk("rsp_data", rsp_data, exp_d);
        chk("grant_tag", grant_tag, 32'(w));
        chk("deliver_req_busy", req_busy, ALL1);
        if (exp_nan) begin
            err_model = 1;
            fires++;
        end
        chk("err_timeout", err_timeout, 32'(err_model));
        chk("m_rst_at_deliver", m_rst, 32'(exp_nan));
        d0 = rsp_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rsp_stb", rsp_stb, oh);
            chk("bp_rsp_data", rsp_data, d0);
            chk("bp_req_busy", req_busy, ALL1);
        end
        rsp_busy = noh;
        @(negedge clk);
        chk("rsp_cleared", rsp_stb, 0);
        chk("m_rst_low", m_rst, 0);
        chk("mrst_pulses", mrst_hi, fires);
        model_rr = (w + 1) % NREQ;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not reach the end");
        $fatal(1, "time limit");
    end

    initial begin
        int seen;
        rst = 1'b1;
        req_stb = '0;
        req_a = '0;
        req_b = '0;
        rsp_busy = '0;
        m_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_stb", rsp_stb, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_m_input_stb", m_input_stb, 0);
        chk("rst_m_a", m_a, 0);
        chk("rst_m_b", m_b, 0);
        chk("rst_m_output_busy", m_output_busy, 1);
        chk("rst_err", err_timeout, 0);
        chk("rst_grant_tag", grant_tag, 0);
        chk("rst_m_rst", m_rst, 1);
        chk("rst_req_busy_none", req_busy, ALL1);
        req_stb = 3'b110;
        #1;
        chk("rst_req_busy_winner", req_busy, 3'b101);
        req_stb = '0;
        rst = 1'b0;

        // Single operation from requester 0: 2.0 * 3.0.
        a_arr[0] = 32'h40000000; b_arr[0] = 32'h40400000;
        a_arr[1] = 32'hC0000000; b_arr[1] = 32'h3F000000;
        a_arr[2] = 32'h3F800000; b_arr[2] = 32'h3F800000;
        one_op(3'b001, 2, 0, 0, 0, 0);
        chk("single_value", rsp_data, 32'h40C00000);

        // Contention: both held, grants alternate.
        a_arr[0] = 32'h3FC00000; b_arr[0] = 32'h3FC00000;
        for (int i = 0; i < 4; i++) one_op(3'b011, 1, 0, 0, 0, 0);
        chk("contend_value0", fp_mul(a_arr[0], b_arr[0]), 32'h40100000);
        chk("contend_value1", fp_mul(a_arr[1], b_arr[1]), 32'hBF800000);

        // Backpressure on requester 1 while requester 0 waits; then an issue stall.
        one_op(3'b011, 3, 0, 0, 10, 0);
        one_op(3'b011, 0, 0, 0, 0, 3);

        // Hung multiplier, then a good op with the flag still set.
        a_arr[2] = rand_fp(); b_arr[2] = rand_fp();
        one_op(3'b100, 0, 1, 1, 0, 0);
        one_op(3'b100, 4, 0, 0, 2, 0);

        // Reset while waiting for a result.
        stub_lat = 20;
        stub_hang = 0;
        req_stb = 3'b001;
        rsp_busy = '0;
        repeat (6) @(negedge clk);
        chk("mid_wait_state", m_output_busy, 0);
        req_stb = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_stb", rsp_stb, 0);
        chk("midrst_obusy", m_output_busy, 1);
        chk("midrst_istb", m_input_stb, 0);
        chk("midrst_tag", grant_tag, 0);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_req_busy", req_busy, ALL1);
        rst = 1'b0;
        model_rr = 0;
        err_model = 0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_stb !== '0) seen = 1;
        end
        chk("no_stale_rsp", seen, 0);
        one_op(3'b011, 2, 0, 0, 0, 0);

        // Result on the terminal watchdog cycle wins; one cycle later loses.
        one_op(3'b011, TIMEOUT - 1, 0, 0, 0, 0);
        one_op(3'b011, TIMEOUT, 0, 1, 0, 0);

        // Random traffic.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = rand_fp();
                b_arr[i] = rand_fp();
            end
            one_op(NREQ'($urandom_range(1, 7)), $urandom_range(0, 6), 0, 0,
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Shares one fp32 multiplier (STB/BUSY handshake on input and output) between NREQ requesters, e.g. the PicoRV32 co-processor port and a DMA/vector engine. Round-robin arbitration, one operation in flight, result routed back to the issuing requester. Watchdog detects a hung multiplier: pulses a multiplier reset and returns a canonical NaN with a sticky error flag.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT_RESULT before watchdog fires (>=32)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_stb  in  NREQ  requester i operands valid
req_a  in  32*NREQ  operand A, slice i = [32*i+31:32*i]
req_b  in  32*NREQ  operand B, same slicing
req_busy  out  NREQ  high = arbiter not accepting from requester i
rsp_data  out  32  result bus, shared by all requesters
rsp_stb  out  NREQ  result valid for requester i (at most one bit set)
rsp_busy  in  NREQ  requester i cannot take result
m_a  out  32  multiplier operand A
m_b  out  32  multiplier operand B
m_input_stb  out  1  operands valid to multiplier
m_busy  in  1  multiplier busy
m_result  in  32  multiplier result
m_output_stb  in  1  multiplier result valid
m_output_busy  out  1  arbiter cannot take result
m_rst  out  1  multiplier reset = rst OR watchdog pulse
err_timeout  out  1  sticky watchdog flag
grant_tag  out  log2(NREQ) (min 1)  requester index of operation in flight

Behaviour:
- Transfer rule on every interface: occurs on the rising edge where STB=1 and BUSY=0 are sampled together.
- Reset: state=IDLE; rr_ptr=0; req_busy = all 1 except winner per IDLE rule; rsp_stb=0; rsp_data=0; m_input_stb=0; m_a=m_b=0; m_output_busy=1; err_timeout=0; grant_tag=0; wdog=0. Reset mid-operation discards the in-flight op; no rsp_stb is ever issued for it.
- States: IDLE, ISSUE, WAIT_RESULT, DELIVER.
- IDLE: winner = first i with req_stb[i]=1 searching rr_ptr, rr_ptr+1, ... mod NREQ. req_busy[i]=0 only for winner (combinational from req_stb and rr_ptr); all others 1; all 1 if no req_stb. On transfer: latch operands into m_a/m_b, grant_tag=i, rr_ptr=(i+1) mod NREQ, m_input_stb<=1, go ISSUE.
- ISSUE: hold m_a/m_b/m_input_stb stable. When m_busy=0: m_input_stb<=0, m_output_busy<=0, wdog<=0, go WAIT_RESULT.
- WAIT_RESULT: m_output_busy=0. When m_output_stb=1: rsp_data<=m_result, rsp_stb[grant_tag]<=1, m_output_busy<=1, go DELIVER. Otherwise wdog increments; when wdog reaches TIMEOUT-1: err_timeout<=1, m_rst pulses high exactly 1 cycle, rsp_data<=32'hFFC00000, rsp_stb[grant_tag]<=1, go DELIVER.
- DELIVER: hold rsp_data/rsp_stb until rsp_busy[grant_tag]=0. On transfer: rsp_stb<=0, go IDLE. req_busy all 1.
- Throughput: one op at a time; minimum arbiter overhead is 3 cycles plus multiplier latency.
- Fairness: a requester holding req_stb continuously is granted at least once every NREQ operations.
- Simultaneous events: a request arriving while not IDLE waits (req_busy=1), with no loss. A result arriving on the same edge the watchdog fires takes priority: the real result is delivered, err_timeout is not set, and m_rst does not pulse.
- err_timeout clears only on rst.

Test Plan:
- Single op: req0 a=0x40000000 b=0x40400000 -> rsp_stb[0] with rsp_data=0x40C00000; rsp_stb[1] stays 0; grant_tag=0.
- Contention: req_stb=2'b11 held. Req0 1.5*1.5 (0x3FC00000 each), req1 0xC0000000*0x3F000000 -> grants alternate 0,1,0,1; results 0x40100000 to req0 and 0xBF800000 to req1.
- Backpressure: rsp_busy[1]=1 for 10 cycles during DELIVER -> rsp_data/rsp_stb[1] stable; req0 stays req_busy=1 until delivery completes.
- Watchdog: stub multiplier never asserts m_output_stb -> after TIMEOUT cycles, 1-cycle m_rst pulse, rsp_data=0xFFC00000, err_timeout=1 and stays 1 through further good ops.
- Reset mid-WAIT_RESULT: assert rst -> next cycle state IDLE, all rsp_stb=0, the pending result is never delivered, and a fresh op completes correctly.
- Race: m_output_stb first asserted on the watchdog terminal cycle -> real result delivered, err_timeout=0.
